// File: rtl/avmm_lvds_bridge_avm_if_if.sv
// avmm_lvds_bridge_avm_if_if: request FIFO, Avalon-MM master and response FIFO signals of the far-end bridge core
interface avmm_lvds_bridge_avm_if_if #(
  parameter int BURSTCNT_W = 11,
  parameter int ADDR_W = 19
);
  logic [31:0] req_q_i;
  logic req_rdempty_i;
  logic req_rdreq_o;
  logic [ADDR_W-1:0] m_address_o;
  logic [3:0] m_byteenable_o;
  logic [31:0] m_writedata_o;
  logic m_write_o;
  logic m_read_o;
  logic [BURSTCNT_W-1:0] m_burstcount_o;
  logic [31:0] m_readdata_i;
  logic m_readdatavalid_i;
  logic m_waitrequest_i;
  logic [31:0] resp_data_o;
  logic resp_valid_o;
  logic busy_o;
  modport master (
    input req_q_i, req_rdempty_i, m_readdata_i, m_readdatavalid_i, m_waitrequest_i,
    output req_rdreq_o, m_address_o, m_byteenable_o, m_writedata_o, m_write_o, m_read_o,
    output m_burstcount_o, resp_data_o, resp_valid_o, busy_o
  );
  modport slave (
    output req_q_i, req_rdempty_i, m_readdata_i, m_readdatavalid_i, m_waitrequest_i,
    input req_rdreq_o, m_address_o, m_byteenable_o, m_writedata_o, m_write_o, m_read_o,
    input m_burstcount_o, resp_data_o, resp_valid_o, busy_o
  );
endinterface

// File: rtl/avmm_lvds_bridge_avm_if.sv
// avmm_lvds_bridge_avm_if: replays request-FIFO packets as Avalon-MM transactions and returns read data
module avmm_lvds_bridge_avm_if #(
  parameter int BURSTCNT_W = 11,
  parameter int ADDR_W = 19
) (
  input logic clk_i,
  input logic rst_i,
  avmm_lvds_bridge_avm_if_if.master bus
);
  typedef enum logic [2:0] {IDLE, BCNT, WR, RD_CMD, RD_DATA} state_t;
  state_t r_state, w_next;
  logic r_rd;
  logic [3:0] r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [BURSTCNT_W-1:0] r_bcnt, r_beats, w_word1_bcnt;
  logic [31:0] r_resp_data;
  logic r_resp_valid;
  logic w_pop, w_wr_acc, w_rd_beat, w_last;
  assign w_word1_bcnt = bus.req_q_i[BURSTCNT_W-1:0] == '0 ? BURSTCNT_W'(1) : bus.req_q_i[BURSTCNT_W-1:0];
  assign w_wr_acc = r_state == WR && !bus.req_rdempty_i && !bus.m_waitrequest_i;
  assign w_rd_beat = (r_state == RD_CMD || r_state == RD_DATA) && bus.m_readdatavalid_i;
  assign w_last = r_beats == BURSTCNT_W'(1);
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    case (r_state)
      IDLE: if (!bus.req_rdempty_i) begin
        w_pop = 1'b1;
        w_next = bus.req_q_i[31] ? BCNT : bus.req_q_i[30] ? RD_CMD : WR;
      end
      BCNT: if (!bus.req_rdempty_i) begin
        w_pop = 1'b1;
        w_next = r_rd ? RD_CMD : WR;
      end
      WR: begin
        w_pop = w_wr_acc;
        w_next = w_wr_acc && w_last ? IDLE : WR;
      end
      RD_CMD: w_next = bus.m_waitrequest_i ? RD_CMD : w_rd_beat && w_last ? IDLE : RD_DATA;
      RD_DATA: w_next = w_rd_beat && w_last ? IDLE : RD_DATA;
      default: w_next = IDLE;
    endcase
  end
  // Address, byteenable and burstcount are captured once per packet and held for the whole transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_rd <= 1'b0;
      r_be <= '0;
      r_addr <= '0;
      r_bcnt <= '0;
      r_beats <= '0;
      r_resp_data <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_resp_valid <= w_rd_beat;
      if (w_rd_beat) r_resp_data <= bus.m_readdata_i;
      if (r_state == IDLE && w_pop) begin
        r_rd <= bus.req_q_i[30];
        r_be <= bus.req_q_i[31] ? 4'hF : bus.req_q_i[29:26];
        r_addr <= bus.req_q_i[ADDR_W-1:0];
        r_bcnt <= BURSTCNT_W'(1);
        r_beats <= BURSTCNT_W'(1);
      end
      if (r_state == BCNT && w_pop) begin
        r_bcnt <= w_word1_bcnt;
        r_beats <= w_word1_bcnt;
      end
      if (w_wr_acc || w_rd_beat) r_beats <= r_beats - 1'b1;
    end
  end
  assign bus.req_rdreq_o = w_pop;
  assign bus.m_address_o = r_addr;
  assign bus.m_byteenable_o = r_be;
  assign bus.m_burstcount_o = r_bcnt;
  assign bus.m_write_o = r_state == WR && !bus.req_rdempty_i;
  assign bus.m_writedata_o = r_state == WR ? bus.req_q_i : '0;
  assign bus.m_read_o = r_state == RD_CMD;
  assign bus.resp_data_o = r_resp_data;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.busy_o = r_state != IDLE;
endmodule

// File: tb/tb_avmm_lvds_bridge_avm_if.sv
// tb_avmm_lvds_bridge_avm_if: randomized packet traffic checked against a queue-based transaction model
module tb_avmm_lvds_bridge_avm_if;
  localparam int BW = 11;
  localparam int AW = 19;
  typedef struct {
    logic [AW-1:0] a;
    logic [3:0] be;
    logic [BW-1:0] bc;
    logic [31:0] d;
    bit last;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  avmm_lvds_bridge_avm_if_if #(.BURSTCNT_W(BW), .ADDR_W(AW)) bus();
  avmm_lvds_bridge_avm_if #(.BURSTCNT_W(BW), .ADDR_W(AW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  beat_t exp_wr[$], exp_rd[$];
  logic [31:0] fifo[$], exp_resp[$];
  int len_q[$];
  int checks = 0, errors = 0;
  int p_wait = 0, p_empty = 0, p_rdv = 100, wait_hold = 0, rdv_budget = -1, junk = 0, rd_pend = 0;
  int n_resp = 0, n_pop = 0, n_pushed = 0, rd_hi = 0, rd_left = 0;
  bit idle_next = 0, use_fix = 0;
  logic [31:0] fix_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  task automatic add_pkt(input logic [1:0] op, input logic [3:0] be, input logic [AW-1:0] a, input logic [BW-1:0] bc_raw);
    int n;
    logic [31:0] w0, w1, d;
    logic [3:0] ebe;
    n = op[1] ? (bc_raw == 0 ? 1 : int'(bc_raw)) : 1;
    ebe = op[1] ? 4'hF : be;
    w0 = {op, be, 26'($urandom)};
    w0[AW-1:0] = a;
    fifo.push_back(w0);
    n_pushed++;
    if (op[1]) begin
      w1 = $urandom;
      w1[BW-1:0] = bc_raw;
      fifo.push_back(w1);
      n_pushed++;
    end
    if (op[0]) begin
      exp_rd.push_back('{a, ebe, BW'(n), 32'h0, 1'b1});
      len_q.push_back(n);
    end else for (int i = 0; i < n; i++) begin
      d = $urandom;
      fifo.push_back(d);
      n_pushed++;
      exp_wr.push_back('{a, ebe, BW'(n), d, i == n - 1});
    end
  endtask

  // One clock of the FIFO and Avalon slave environment; inputs change just after the rising edge
  task automatic cyc();
    logic pop, racc;
    @(negedge clk);
    pop = bus.req_rdreq_o;
    racc = bus.m_read_o && !bus.m_waitrequest_i && !rst;
    @(posedge clk);
    #1;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    if (racc && len_q.size() > 0) rd_pend += len_q.pop_front();
    bus.m_readdatavalid_i = 1'b0;
    if (junk > 0) begin
      junk--;
      bus.m_readdatavalid_i = 1'b1;
      bus.m_readdata_i = $urandom;
    end else if (rd_pend > 0 && rdv_budget != 0 && $urandom_range(99) < p_rdv) begin
      rd_pend--;
      if (rdv_budget > 0) rdv_budget--;
      bus.m_readdata_i = use_fix ? fix_data : $urandom;
      bus.m_readdatavalid_i = 1'b1;
      exp_resp.push_back(bus.m_readdata_i);
    end
    if (wait_hold > 0) begin
      wait_hold--;
      bus.m_waitrequest_i = 1'b1;
    end else bus.m_waitrequest_i = $urandom_range(99) < p_wait;
    bus.req_rdempty_i = fifo.size() == 0 || $urandom_range(99) < p_empty;
    bus.req_q_i = fifo.size() > 0 ? fifo[0] : 32'h0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((fifo.size() || exp_wr.size() || exp_rd.size() || exp_resp.size() || rd_pend || bus.busy_o) && k < 6000) begin
      cyc();
      k++;
    end
    if (k >= 6000) fail({name, "_drain_timeout"});
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      rd_left = 0;
      idle_next = 0;
    end else begin
      if (idle_next) begin
        chk("busy_after_write", bus.busy_o, 0);
        idle_next = 0;
      end
      if (bus.m_read_o) rd_hi++;
      if (bus.req_rdreq_o) begin
        n_pop++;
        chk("pop_while_empty", bus.req_rdempty_i, 0);
      end
      if (bus.m_write_o) chk("write_while_empty", bus.req_rdempty_i, 0);
      if (bus.m_write_o && bus.m_read_o) fail("read_and_write");
      if (bus.m_write_o && !bus.m_waitrequest_i) begin
        if (exp_wr.size() == 0) fail("unexpected_write");
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", bus.m_address_o, e.a);
          chk("wr_be", bus.m_byteenable_o, e.be);
          chk("wr_bc", bus.m_burstcount_o, e.bc);
          chk("wr_data", bus.m_writedata_o, e.d);
          idle_next = e.last;
        end
      end
      if (bus.m_read_o && !bus.m_waitrequest_i) begin
        if (exp_rd.size() == 0) fail("unexpected_read");
        else begin
          e = exp_rd.pop_front();
          chk("rd_addr", bus.m_address_o, e.a);
          chk("rd_be", bus.m_byteenable_o, e.be);
          chk("rd_bc", bus.m_burstcount_o, e.bc);
          rd_left = int'(e.bc);
        end
      end
      if (bus.resp_valid_o) begin
        n_resp++;
        if (exp_resp.size() == 0) fail("unexpected_resp");
        else chk("resp_data", bus.resp_data_o, exp_resp.pop_front());
        if (rd_left > 0) begin
          rd_left--;
          if (rd_left == 0) chk("busy_after_read", bus.busy_o, 0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r0, p0;
    bus.req_q_i = '0;
    bus.req_rdempty_i = 1'b1;
    bus.m_readdata_i = '0;
    bus.m_readdatavalid_i = 1'b0;
    bus.m_waitrequest_i = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_read", bus.m_read_o, 0);
    chk("rst_write", bus.m_write_o, 0);
    chk("rst_rdreq", bus.req_rdreq_o, 0);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_resp_data", bus.resp_data_o, 0);
    chk("rst_addr", bus.m_address_o, 0);
    chk("rst_bc", bus.m_burstcount_o, 0);
    rst = 1'b0;
    cyc();
    // single write with literal expectation
    fifo.push_back(32'h2C00_0123);
    fifo.push_back(32'hDEAD_BEEF);
    n_pushed += 2;
    exp_wr.push_back('{19'h123, 4'hB, 11'd1, 32'hDEAD_BEEF, 1'b1});
    r0 = n_resp;
    drain("single_write");
    chk("single_write_no_resp", n_resp - r0, 0);
    // single read: waitrequest for 3 cycles, data two cycles after acceptance
    p_wait = 100;
    p_rdv = 0;
    use_fix = 1;
    fix_data = 32'h1234_5678;
    r0 = rd_hi;
    add_pkt(2'b01, 4'h5, 19'h4_0ABC, 0);
    k = 0;
    while (!bus.m_read_o && k < 50) begin
      cyc();
      k++;
    end
    p_wait = 0;
    wait_hold = 2;
    repeat (4) cyc();
    p_rdv = 100;
    repeat (2) cyc();
    chk("single_read_valid", bus.resp_valid_o, 1);
    chk("single_read_data", bus.resp_data_o, 32'h1234_5678);
    drain("single_read");
    chk("single_read_cycles", rd_hi - r0, 4);
    use_fix = 0;
    // gapped burst write of 4 beats
    p_wait = 40;
    p_empty = 40;
    p0 = n_pop;
    add_pkt(2'b10, 4'h3, 19'h7_1234, 4);
    drain("burst_write");
    chk("burst_write_pops", n_pop - p0, 6);
    // burst read of 8 with gapped readdatavalid
    p_rdv = 50;
    r0 = n_resp;
    add_pkt(2'b11, 4'h1, 19'h0_0F0F, 8);
    drain("burst_read");
    chk("burst_read_resps", n_resp - r0, 8);
    // burstcount 0 means 1
    r0 = n_resp;
    add_pkt(2'b11, 4'h0, 19'h5_5555, 0);
    k = 0;
    while (!bus.m_read_o && k < 50) begin
      cyc();
      k++;
    end
    chk("bc0_burstcount", bus.m_burstcount_o, 1);
    drain("bc0_read");
    chk("bc0_resps", n_resp - r0, 1);
    // maximum burstcount completes without wrap
    p_rdv = 100;
    p_wait = 20;
    p_empty = 0;
    r0 = n_resp;
    add_pkt(2'b11, 4'h0, 19'h1_0001, 11'h7FF);
    drain("max_read");
    chk("max_read_resps", n_resp - r0, 2047);
    // random traffic
    for (int i = 0; i < 150; i++) begin
      if (i % 50 == 0) begin
        p_wait = $urandom_range(60);
        p_empty = $urandom_range(60);
        p_rdv = $urandom_range(30, 100);
      end
      add_pkt(2'($urandom), 4'($urandom), AW'($urandom), $urandom_range(9) == 0 ? BW'($urandom_range(20)) : BW'($urandom_range(5)));
      repeat ($urandom_range(3)) cyc();
    end
    drain("random");
    // reset in the middle of an 8-beat read after 3 responses
    p_wait = 0;
    p_empty = 0;
    p_rdv = 100;
    rdv_budget = 3;
    r0 = n_resp;
    add_pkt(2'b11, 4'h0, 19'h2_2222, 8);
    k = 0;
    while ((n_resp - r0 < 3 || exp_resp.size() > 0) && k < 100) begin
      cyc();
      k++;
    end
    chk("mid_reset_resps_before", n_resp - r0, 3);
    rst = 1'b1;
    cyc();
    chk("mid_reset_read", bus.m_read_o, 0);
    chk("mid_reset_resp_valid", bus.resp_valid_o, 0);
    chk("mid_reset_busy", bus.busy_o, 0);
    rst = 1'b0;
    rd_pend = 0;
    rdv_budget = -1;
    junk = 5;
    repeat (10) cyc();
    chk("mid_reset_resps_after", n_resp - r0, 3);
    drain("final");
    repeat (3) cyc();
    chk("total_pops", n_pop, n_pushed);
    chk("leftover_writes", exp_wr.size(), 0);
    chk("leftover_reads", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
